param_fifo: RTL and testbench
=============================

Name: param_fifo

Overview:
Next-generation synchronous single-clock FIFO for the dot-product datapath and its FSM controllers.
- Generalised in data width and depth (address width derived, not passed).
- Adds occupancy count, programmable almost-full/almost-empty thresholds and read-while-full pass-through.
- Adds sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
DEPTH, 8, number of entries; power of 2, >=2
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH
(local) AW, clog2(DEPTH), pointer width

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  reset, synchronous, active-low
wr_en  input  1  write request
data_in  input  DATA_WIDTH  write data
rd_en  input  1  read request (FWFT: pop current head)
data_out  output  DATA_WIDTH  read data
valid  output  1  data_out holds a freshly read word (see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write rejected
underflow  output  1  sticky: read rejected
clr_err  input  1  clears overflow/underflow

Behaviour:
- Clock and reset: clk; rstn synchronous, active-low.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, valid=0, data_out=0, overflow=0, underflow=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored data; the first cycle after reset behaves exactly as after power-up.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). Writing while full is accepted only if a read is accepted in the same cycle.
- Reading while empty is never accepted, even with a simultaneous write. There is no write-to-read bypass.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments and wraps naturally modulo DEPTH (AW bits).
- On rd_acc: rd_ptr increments and wraps the same way.
- Count update:
  - count <= count + 1 on wr_acc only.
  - count <= count - 1 on rd_acc only.
  - count unchanged when both or neither are accepted.
- All status flags are registered and derived from the next-state count. They are therefore consistent with count in the same cycle, with no combinational dependence on wr_en/rd_en.
- FWFT=0 (standard mode):
  - On rd_acc, data_out <= mem[rd_ptr]; valid=1 in the following cycle only (1-cycle pulse). Read latency is 1 cycle.
  - data_out holds its value when there is no read.
- FWFT=1 (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally when !empty; 0 when empty.
  - valid = !empty.
  - rd_en acknowledges the presented word.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Error flags:
  - overflow <= 1 when wr_en && !wr_acc.
  - underflow <= 1 when rd_en && !rd_acc.
  - clr_err clears both flags; a set event in the same cycle wins over clr_err.
  - Rejected operations change no pointer, count or memory.
- Elaboration errors: DEPTH not a power of 2, or violating 0 <= AE_THRESH < AF_THRESH <= DEPTH.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 constant function;
  - the FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1).
- The package is reused by the dot-product FSMs.
- One natural sub-module: fifo_mem, a simple dual-port RAM with synchronous write and asynchronous read (parameters DATA_WIDTH, DEPTH).
- param_fifo keeps pointers, count, flags and output register.

Test Plan:
- Reset check, DEPTH=8, FWFT=0: hold rstn=0 for 2 cycles -> empty=1, almost_empty=1, full=0, count=0, data_out=0, valid=0, overflow=0, underflow=0.
- Fill then drain:
  - Write 0x01..0x08 -> full=1, count=8, almost_full=1 from count=7.
  - 9th write 0xAA -> rejected, overflow=1, count stays 8.
  - Read 8 -> data_out 0x01..0x08 each 1 cycle after rd_en, valid pulses, empty=1.
- Simultaneous read+write while full (count=8): wr 0x55 plus rd -> both accepted, count=8, full stays 1; 0x55 read back in order after 7 more reads.
- Read empty with same-cycle write of 0x33: rd rejected, underflow=1, count=1. Then clr_err -> underflow=0. Then clr_err together with another empty read -> underflow stays 1.
- FWFT=1: write 0x42 into empty FIFO -> next cycle valid=1, data_out=0x42. rd_en -> next cycle empty=1, valid=0, data_out=0.
- Wrap and reset mid-stream: 20 interleaved wr/rd with ptr wrap -> data order preserved. Assert rstn=0 with count=5 -> count=0, empty=1; old data is never output.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and width helpers.
// Also imported by the dot-product FSM controllers.
package fifo_pkg;

   // Read-mode selector values for the FWFT parameter
   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Number of bits needed to address 'value' entries (ceil(log2(value)))
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // True when value is a non-zero power of two
   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for param_fifo: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   localparam int AW        = clog2(DEPTH)
)(
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: store the word on the rising edge when enabled
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port is combinational so the FIFO can present the head word
   // without an extra cycle of latency in fall-through mode.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable
// first-word-fall-through read mode.
module param_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int FWFT       = FIFO_STD,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   localparam int AW        = clog2(DEPTH)
)(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [AW:0]           count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   // Parameter sanity: stop elaboration on an unusable configuration
   generate
      if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
         $error("param_fifo: DEPTH must be a power of 2 and at least 2");
      end
      if ((AE_THRESH < 0) || (AE_THRESH >= AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
         $error("param_fifo: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
      end
      if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
         $error("param_fifo: FWFT must be FIFO_STD or FIFO_FWFT");
      end
      if (DATA_WIDTH < 1) begin : g_bad_width
         $error("param_fifo: DATA_WIDTH must be at least 1");
      end
   endgenerate

   // Threshold constants sized to the count so comparisons stay width-clean
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

   logic [AW-1:0]         wr_ptr_reg;
   logic [AW-1:0]         rd_ptr_reg;
   logic [AW:0]           count_reg;
   logic [AW:0]           count_next;
   logic                  full_reg;
   logic                  empty_reg;
   logic                  almost_full_reg;
   logic                  almost_empty_reg;
   logic                  overflow_reg;
   logic                  underflow_reg;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [DATA_WIDTH-1:0] mem_rdata;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_reg),
      .wr_data (data_in),
      .rd_addr (rd_ptr_reg),
      .rd_data (mem_rdata)
   );

   // Accept logic: a read needs data; a write needs room, or a same-cycle
   // accepted read that frees a slot. Empty reads are never satisfied by a
   // simultaneous write.
   always_comb begin
      rd_acc = rd_en && !empty_reg;
      wr_acc = wr_en && (!full_reg || rd_acc);
   end

   // Next occupancy: a simultaneous accepted read and write cancel out
   always_comb begin
      count_next = count_reg;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Pointers, count and status flags; flags come from the next count so
   // they always agree with count in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         full_reg         <= 1'b0;
         empty_reg        <= 1'b1;
         almost_full_reg  <= 1'b0;
         almost_empty_reg <= 1'b1;
      end else begin
         if (wr_acc) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg        <= count_next;
         full_reg         <= (count_next == DEPTH_C);
         empty_reg        <= (count_next == '0);
         almost_full_reg  <= (count_next >= AF_C);
         almost_empty_reg <= (count_next <= AE_C);
      end
   end

   // Sticky error flags: a new rejection wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (!rstn) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_en && !wr_acc) begin
            overflow_reg <= 1'b1;
         end else if (clr_err) begin
            overflow_reg <= 1'b0;
         end
         if (rd_en && !rd_acc) begin
            underflow_reg <= 1'b1;
         end else if (clr_err) begin
            underflow_reg <= 1'b0;
         end
      end
   end

   // Read-data path depends on the selected mode
   generate
      if (FWFT == FIFO_FWFT) begin : g_fwft
         // Head word is shown directly; forced to zero when nothing is stored
         assign data_out = empty_reg ? '0 : mem_rdata;
         assign valid    = !empty_reg;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] data_out_reg;
         logic                  valid_reg;

         // Registered read: capture the head on an accepted read, pulse valid
         always_ff @(posedge clk) begin
            if (!rstn) begin
               data_out_reg <= '0;
               valid_reg    <= 1'b0;
            end else begin
               valid_reg <= rd_acc;
               if (rd_acc) begin
                  data_out_reg <= mem_rdata;
               end
            end
         end

         assign data_out = data_out_reg;
         assign valid    = valid_reg;
      end
   endgenerate

   assign full         = full_reg;
   assign empty        = empty_reg;
   assign almost_full  = almost_full_reg;
   assign almost_empty = almost_empty_reg;
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: a standard-mode and a fall-through
// instance share the same stimulus and are compared against a queue model.
module tb_param_fifo;
   import fifo_pkg::*;

   localparam int DW      = 8;
   localparam int DEPTH   = 8;
   localparam int S_AF    = 7;
   localparam int S_AE    = 1;
   localparam int F_AF    = 6;
   localparam int F_AE    = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic          wr_en;
   logic          rd_en;
   logic          clr_err;
   logic [DW-1:0] data_in;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_valid, f_valid, s_full, f_full, s_empty, f_empty;
   logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
   logic [3:0]    s_count, f_count;

   // Reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_dout;
   bit            exp_valid;
   bit            exp_ovf;
   bit            exp_udf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   param_fifo #(
      .DATA_WIDTH (DW), .DEPTH (DEPTH), .FWFT (FIFO_STD),
      .AF_THRESH (S_AF), .AE_THRESH (S_AE)
   ) dut_std (
      .clk (clk), .rstn (rstn), .wr_en (wr_en), .data_in (data_in),
      .rd_en (rd_en), .data_out (s_dout), .valid (s_valid),
      .full (s_full), .empty (s_empty), .almost_full (s_af),
      .almost_empty (s_ae), .count (s_count), .overflow (s_ovf),
      .underflow (s_udf), .clr_err (clr_err)
   );

   param_fifo #(
      .DATA_WIDTH (DW), .DEPTH (DEPTH), .FWFT (FIFO_FWFT),
      .AF_THRESH (F_AF), .AE_THRESH (F_AE)
   ) dut_fwft (
      .clk (clk), .rstn (rstn), .wr_en (wr_en), .data_in (data_in),
      .rd_en (rd_en), .data_out (f_dout), .valid (f_valid),
      .full (f_full), .empty (f_empty), .almost_full (f_af),
      .almost_empty (f_ae), .count (f_count), .overflow (f_ovf),
      .underflow (f_udf), .clr_err (clr_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic compare_all();
      int n;
      n = q.size();
      check("s_count",  32'(s_count), 32'(n));
      check("s_full",   32'(s_full),  32'(n == DEPTH));
      check("s_empty",  32'(s_empty), 32'(n == 0));
      check("s_afull",  32'(s_af),    32'(n >= S_AF));
      check("s_aempty", 32'(s_ae),    32'(n <= S_AE));
      check("s_ovf",    32'(s_ovf),   32'(exp_ovf));
      check("s_udf",    32'(s_udf),   32'(exp_udf));
      check("s_valid",  32'(s_valid), 32'(exp_valid));
      check("s_dout",   32'(s_dout),  32'(exp_dout));
      check("f_count",  32'(f_count), 32'(n));
      check("f_full",   32'(f_full),  32'(n == DEPTH));
      check("f_empty",  32'(f_empty), 32'(n == 0));
      check("f_afull",  32'(f_af),    32'(n >= F_AF));
      check("f_aempty", 32'(f_ae),    32'(n <= F_AE));
      check("f_ovf",    32'(f_ovf),   32'(exp_ovf));
      check("f_udf",    32'(f_udf),   32'(exp_udf));
      check("f_valid",  32'(f_valid), 32'(n > 0));
      check("f_dout",   32'(f_dout),  (n > 0) ? 32'(q[0]) : 32'h0);
   endtask

   // One clock of stimulus: update the model from the FIFO rules, clock the
   // DUTs, then compare everything just after the edge.
   task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
      bit ra;
      bit wa;
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      clr_err = c;
      if (!rstn) begin
         q.delete();
         exp_dout  = '0;
         exp_valid = 1'b0;
         exp_ovf   = 1'b0;
         exp_udf   = 1'b0;
      end else begin
         ra = r && (q.size() > 0);
         wa = w && ((q.size() < DEPTH) || ra);
         exp_valid = ra;
         if (ra) exp_dout = q.pop_front();
         if (wa) q.push_back(d);
         if (w && !wa) exp_ovf = 1'b1;
         else if (c)   exp_ovf = 1'b0;
         if (r && !ra) exp_udf = 1'b1;
         else if (c)   exp_udf = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      $display("cyc=%0d rstn=%0b wr=%0b rd=%0b din=%02h clr=%0b count=%0d s_dout=%02h s_valid=%0b f_dout=%02h",
               cyc, rstn, w, r, d, c, s_count, s_dout, s_valid, f_dout);
      compare_all();
   endtask

   initial begin
      rstn    = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      data_in = '0;

      // Reset held for two cycles
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      rstn = 1'b1;

      // Fill 0x01..0x08, then a rejected ninth write
      for (int i = 1; i <= DEPTH; i++) step(1, 0, 8'(i), 0);
      step(1, 0, 8'hAA, 0);
      step(0, 0, 8'h00, 1);

      // Drain all eight
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // Refill, then read+write while full, then drain including 0x55
      for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h10 + i), 0);
      step(1, 1, 8'h55, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0);

      // Empty read with same-cycle write, clear, then clear racing a new underflow
      step(1, 1, 8'h33, 0);
      step(0, 0, 8'h00, 1);
      step(0, 1, 8'h00, 0);
      step(0, 1, 8'h00, 1);
      step(0, 0, 8'h00, 1);

      // Fall-through first word
      step(1, 0, 8'h42, 0);
      step(0, 0, 8'h00, 0);
      step(0, 1, 8'h00, 0);

      // Randomized traffic alternating fill-heavy and drain-heavy phases
      for (int i = 0; i < 240; i++) begin
         int wp;
         wp = ((i / 30) % 2 == 0) ? 75 : 30;
         step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
              8'($urandom), $urandom_range(0, 15) == 0);
      end

      // Bring occupancy to exactly five, then reset mid-stream
      for (int i = 0; i < 40 && q.size() != 5; i++) begin
         step(q.size() < 5, q.size() > 5, 8'($urandom), 0);
      end
      rstn = 1'b0;
      step(1, 1, 8'hEE, 0);
      rstn = 1'b1;
      step(0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      step(1, 0, 8'h77, 0);
      step(1, 1, 8'h78, 0);
      step(0, 1, 8'h00, 0);
      step(0, 1, 8'h00, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
